// File: rtl/keypad_entry_ctrl_pkg.sv
// rtl/keypad_entry_ctrl_pkg.sv - shared types and key bit map for keypad operand entry
package keypad_entry_ctrl_pkg;

    typedef enum logic {
        EDIT    = 1'b0,
        CONFIRM = 1'b1
    } entry_state_e;

    localparam int DIGIT_W = 4;

    // key_hex bit positions, shared with the button controller wrapper
    localparam int KEY_0 = 0;
    localparam int KEY_1 = 1;
    localparam int KEY_2 = 2;
    localparam int KEY_3 = 3;
    localparam int KEY_4 = 4;
    localparam int KEY_5 = 5;
    localparam int KEY_6 = 6;
    localparam int KEY_7 = 7;
    localparam int KEY_8 = 8;
    localparam int KEY_9 = 9;
    localparam int KEY_A = 10;
    localparam int KEY_B = 11;
    localparam int KEY_C = 12;
    localparam int KEY_D = 13;
    localparam int KEY_E = 14;
    localparam int KEY_F = 15;

    localparam logic [15:0] KEY_HEX_ALPHA_MASK = 16'hFFFF << KEY_A;

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// rtl/keypad_entry_ctrl_if.sv - key pulse inputs and entry/commit outputs of the entry controller
interface keypad_entry_ctrl_if
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS = 4
);
    localparam int VAL_W = DIGIT_W * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [15:0]      key_hex;
    logic             key_enter;
    logic             key_correct;
    logic             key_back;
    logic             key_yes;
    logic             key_no;
    logic [VAL_W-1:0] entry_value;
    logic [CNT_W-1:0] entry_count;
    logic             confirming;
    logic             commit_valid;
    logic [VAL_W-1:0] commit_value;
    logic             err_pulse;

    modport master (
        output key_hex, key_enter, key_correct, key_back, key_yes, key_no,
        input  entry_value, entry_count, confirming, commit_valid, commit_value, err_pulse
    );

    modport slave (
        input  key_hex, key_enter, key_correct, key_back, key_yes, key_no,
        output entry_value, entry_count, confirming, commit_valid, commit_value, err_pulse
    );

endinterface

// File: rtl/keypad_entry_ctrl_onehot16_enc.sv
// rtl/keypad_entry_ctrl_onehot16_enc.sv - 16-bit one-hot to 4-bit index encoder with multi-hot flag
module onehot16_enc (
    input  logic [15:0] onehot,
    output logic [3:0]  index,
    output logic        valid,
    output logic        multi_hot
);

    always_comb begin
        index     = '0;
        valid     = 1'b0;
        multi_hot = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) begin
                if (valid) multi_hot = 1'b1;
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - multi-digit operand entry with backspace, clear and yes/no commit
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS     = 4,
    parameter bit HEX_EN         = 1'b1,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic               clk,
    input  logic               rst,
    keypad_entry_ctrl_if.slave bus
);

    localparam int VAL_W = DIGIT_W * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    entry_state_e     state_q, state_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [VAL_W-1:0] commit_q, commit_d;
    logic             commit_valid_q, commit_valid_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [3:0] digit_idx;
    logic       digit_any;
    logic       digit_multi;
    logic       digit_bad;
    logic       any_key;

    onehot16_enc u_enc (
        .onehot    (bus.key_hex),
        .index     (digit_idx),
        .valid     (digit_any),
        .multi_hot (digit_multi)
    );

    assign digit_bad = digit_multi
                     || (!HEX_EN && (|(bus.key_hex & KEY_HEX_ALPHA_MASK)))
                     || (count_q == CNT_W'(MAX_DIGITS));
    assign any_key   = digit_any | bus.key_enter | bus.key_correct | bus.key_back
                     | bus.key_yes | bus.key_no;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EDIT;
            value_q        <= '0;
            count_q        <= '0;
            commit_q       <= '0;
            commit_valid_q <= 1'b0;
            err_q          <= 1'b0;
            tmr_q          <= '0;
        end else begin
            state_q        <= state_d;
            value_q        <= value_d;
            count_q        <= count_d;
            commit_q       <= commit_d;
            commit_valid_q <= commit_valid_d;
            err_q          <= err_d;
            tmr_q          <= tmr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        value_d        = value_q;
        count_d        = count_q;
        commit_d       = commit_q;
        commit_valid_d = 1'b0;
        err_d          = 1'b0;
        tmr_d          = tmr_q;
        case (state_q)
            EDIT: begin
                if (bus.key_back) begin
                    value_d = '0;
                    count_d = '0;
                end else if (bus.key_correct) begin
                    if (count_q != '0) begin
                        value_d = value_q >> DIGIT_W;
                        count_d = count_q - 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.key_enter) begin
                    if (count_q != '0) begin
                        state_d = CONFIRM;
                        tmr_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (digit_any) begin
                    if (digit_bad) begin
                        err_d = 1'b1;
                    end else begin
                        value_d = (value_q << DIGIT_W) | VAL_W'(digit_idx);
                        count_d = count_q + 1'b1;
                    end
                end
            end
            CONFIRM: begin
                if (bus.key_back) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = EDIT;
                end else if (bus.key_no) begin
                    state_d = EDIT;
                end else if (bus.key_yes) begin
                    commit_d       = value_q;
                    commit_valid_d = 1'b1;
                    value_d        = '0;
                    count_d        = '0;
                    state_d        = EDIT;
                end else if ((TIMEOUT_CYCLES != 0) && (tmr_q == TMR_LAST)) begin
                    // an unanswered prompt falls back to editing, keeping the digits
                    state_d = EDIT;
                    err_d   = 1'b1;
                end else if (any_key) begin
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    assign bus.entry_value  = value_q;
    assign bus.entry_count  = count_q;
    assign bus.confirming   = (state_q == CONFIRM);
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_value = commit_q;
    assign bus.err_pulse    = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - bench for keypad_entry_ctrl in hex/timeout and decimal/no-timeout builds
module tb_keypad_entry_ctrl;

    typedef struct packed {
        logic [15:0] hex;
        logic        enter;
        logic        correct;
        logic        back;
        logic        yes;
        logic        no;
    } keys_t;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] ENT  = 5'b10000;
    localparam logic [4:0] COR  = 5'b01000;
    localparam logic [4:0] BCK  = 5'b00100;
    localparam logic [4:0] YES  = 5'b00010;
    localparam logic [4:0] NO   = 5'b00001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    keypad_entry_ctrl_if #(.MAX_DIGITS(4)) bus_h ();
    keypad_entry_ctrl_if #(.MAX_DIGITS(4)) bus_d ();

    keypad_entry_ctrl #(.MAX_DIGITS(4), .HEX_EN(1'b1), .TIMEOUT_CYCLES(16)) dut_hex (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    keypad_entry_ctrl #(.MAX_DIGITS(4), .HEX_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_dec (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    logic [37:0] obs_h;
    logic [37:0] obs_d;
    assign obs_h = {bus_h.entry_value, bus_h.entry_count, bus_h.confirming, bus_h.commit_valid,
                    bus_h.commit_value, bus_h.err_pulse};
    assign obs_d = {bus_d.entry_value, bus_d.entry_count, bus_d.confirming, bus_d.commit_valid,
                    bus_d.commit_value, bus_d.err_pulse};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 is the hex build (timeout 16), index 1 the decimal build (no timeout)
    int digs [2][4];
    int cnt  [2];
    bit conf [2];
    int age  [2];
    bit cv   [2];
    bit er   [2];
    int commit [2];

    function automatic keys_t mk(input logic [15:0] h, input logic [4:0] ctl);
        return {h, ctl};
    endfunction

    function automatic int mval(input int c);
        int v = 0;
        for (int i = 0; i < cnt[c]; i++) v = v * 16 + digs[c][i];
        return v;
    endfunction

    function automatic logic [37:0] exp_vec(input int c);
        logic [15:0] v = 16'(mval(c));
        logic [15:0] cm = 16'(commit[c]);
        return {v, 3'(cnt[c]), conf[c], cv[c], cm, er[c]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0; conf[c] = 0; age[c] = 0; cv[c] = 0; er[c] = 0; commit[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input keys_t k);
        int  d = 0;
        int  n = 0;
        bit  hexen = (c == 0);
        int  tmo = (c == 0) ? 16 : 0;
        bit  anyk = (k.hex != 16'h0) || k.enter || k.correct || k.back || k.yes || k.no;
        cv[c] = 0;
        er[c] = 0;
        for (int i = 0; i < 16; i++) if (k.hex[i]) begin d = i; n++; end
        if (!conf[c]) begin
            if (k.back) cnt[c] = 0;
            else if (k.correct) begin
                if (cnt[c] > 0) cnt[c]--; else er[c] = 1;
            end else if (k.enter) begin
                if (cnt[c] > 0) begin conf[c] = 1; age[c] = 0; end else er[c] = 1;
            end else if (n > 0) begin
                if (n > 1 || (!hexen && d >= 10) || cnt[c] == 4) er[c] = 1;
                else begin digs[c][cnt[c]] = d; cnt[c]++; end
            end
        end else begin
            if (k.back) begin cnt[c] = 0; conf[c] = 0; end
            else if (k.no) conf[c] = 0;
            else if (k.yes) begin
                commit[c] = mval(c); cv[c] = 1; cnt[c] = 0; conf[c] = 0;
            end else if (tmo != 0 && age[c] == tmo - 1) begin
                conf[c] = 0; er[c] = 1;
            end else if (anyk) age[c] = 0;
            else age[c]++;
        end
    endtask

    task automatic cycle(input keys_t k);
        bus_h.key_hex = k.hex; bus_h.key_enter = k.enter; bus_h.key_correct = k.correct;
        bus_h.key_back = k.back; bus_h.key_yes = k.yes; bus_h.key_no = k.no;
        bus_d.key_hex = k.hex; bus_d.key_enter = k.enter; bus_d.key_correct = k.correct;
        bus_d.key_back = k.back; bus_d.key_yes = k.yes; bus_d.key_no = k.no;
        for (int c = 0; c < 2; c++) model_step(c, k);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(mk(16'h0, NONE));
        model_reset();
        cycle(mk(16'h0, NONE));
        model_reset();
        n_cmp++;
        if (obs_h !== 38'h0) begin
            n_fail++; $display("FAIL reset_hex got=%h want=%h", obs_h, 38'h0);
        end
        n_cmp++;
        if (obs_d !== exp_vec(1)) begin
            n_fail++; $display("FAIL reset_dec got=%h want=%h", obs_d, exp_vec(1));
        end
        rst = 1'b0;
        cycle(mk(16'h0, YES));
        n_cmp++;
        if (bus_h.commit_valid !== 1'b0 || obs_h !== exp_vec(0)) begin
            n_fail++; $display("FAIL reset_release got=%h want=%h", obs_h, exp_vec(0));
        end
    endtask

    task automatic test_commit();
        keys_t tbl [6];
        tbl = '{mk(16'h0002, NONE), mk(16'h0100, NONE), mk(16'h0800, NONE),
                mk(16'h0, ENT), mk(16'h0, YES), mk(16'h0, NONE)};
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i]);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL commit_hex step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL commit_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
            if (i == 2) begin
                n_cmp++;
                if (bus_h.entry_value !== 16'h018B || bus_h.entry_count !== 3'd3) begin
                    n_fail++; $display("FAIL commit_buffer got=%h/%0d want=018b/3",
                                       bus_h.entry_value, bus_h.entry_count);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (bus_h.commit_valid !== 1'b1 || bus_h.commit_value !== 16'h018B
                    || bus_h.entry_count !== 3'd0) begin
                    n_fail++; $display("FAIL commit_pulse got=%b/%h want=1/018b",
                                       bus_h.commit_valid, bus_h.commit_value);
                end
            end
        end
    endtask

    task automatic test_overflow();
        keys_t tbl [11];
        tbl = '{mk(16'h0, BCK), mk(16'h0002, NONE), mk(16'h0004, NONE), mk(16'h0008, NONE),
                mk(16'h0010, NONE), mk(16'h0020, NONE), mk(16'h0, COR), mk(16'h0, COR),
                mk(16'h0, COR), mk(16'h0, COR), mk(16'h0, COR)};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i]);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL overflow_hex step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL overflow_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
            if (i == 5) begin
                n_cmp++;
                if (bus_h.err_pulse !== 1'b1 || bus_h.entry_value !== 16'h1234) begin
                    n_fail++; $display("FAIL overflow_full got=%b/%h want=1/1234",
                                       bus_h.err_pulse, bus_h.entry_value);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if (bus_h.entry_value !== 16'h0012 || bus_h.entry_count !== 3'd2) begin
                    n_fail++; $display("FAIL overflow_bs got=%h/%0d want=0012/2",
                                       bus_h.entry_value, bus_h.entry_count);
                end
            end
        end
    endtask

    task automatic test_reject();
        keys_t tbl [5];
        tbl = '{mk(16'h0, BCK), mk(16'h0400, NONE), mk(16'h0006, NONE), mk(16'h0, BCK),
                mk(16'h0, ENT)};
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i]);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL reject_hex step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL reject_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
            if (i == 1) begin
                n_cmp++;
                if (bus_d.err_pulse !== 1'b1 || bus_d.entry_count !== 3'd0) begin
                    n_fail++; $display("FAIL reject_alpha got=%b/%0d want=1/0",
                                       bus_d.err_pulse, bus_d.entry_count);
                end
            end
        end
    endtask

    task automatic test_no();
        keys_t tbl [8];
        tbl = '{mk(16'h0, BCK), mk(16'h0010, NONE), mk(16'h0004, NONE), mk(16'h0, ENT),
                mk(16'h0, NO), mk(16'h0, ENT), mk(16'h0, YES | NO), mk(16'h0, NONE)};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i]);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL no_hex step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL no_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
            if (i == 6) begin
                n_cmp++;
                if (bus_h.entry_value !== 16'h0042 || bus_h.confirming !== 1'b0
                    || bus_h.commit_valid !== 1'b0) begin
                    n_fail++; $display("FAIL no_yes_tie got=%h/%b/%b want=0042/0/0",
                                       bus_h.entry_value, bus_h.confirming, bus_h.commit_valid);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int errs = 0;
        cycle(mk(16'h0, BCK));
        cycle(mk(16'h0002, NONE));
        cycle(mk(16'h0, ENT));
        for (int i = 1; i <= 16; i++) begin
            cycle(mk(16'h0, NONE));
            n_cmp++;
            if (obs_h !== exp_vec(0) || bus_h.confirming !== (i < 16)) begin
                n_fail++; $display("FAIL timeout_idle step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
        end
        n_cmp++;
        if (obs_d !== exp_vec(1) || bus_d.confirming !== 1'b1) begin
            n_fail++; $display("FAIL timeout_disabled got=%h want=%h", obs_d, exp_vec(1));
        end
        cycle(mk(16'h0, BCK));
        cycle(mk(16'h0002, NONE));
        cycle(mk(16'h0, ENT));
        for (int i = 1; i <= 26; i++) begin
            cycle(mk((i == 10) ? 16'h0400 : 16'h0, NONE));
            if (bus_h.err_pulse === 1'b1) errs++;
            n_cmp++;
            if (obs_h !== exp_vec(0) || bus_h.confirming !== (i < 26)) begin
                n_fail++; $display("FAIL timeout_restart step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL timeout_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
        end
        n_cmp++;
        if (errs != 1 || bus_h.entry_value !== 16'h0001) begin
            n_fail++; $display("FAIL timeout_err_once got=%0d/%h want=1/0001", errs, bus_h.entry_value);
        end
        cycle(mk(16'h0, NO));
    endtask

    task automatic test_priority();
        keys_t tbl [4];
        tbl = '{mk(16'h0080, NONE), mk(16'h0008, NONE), mk(16'h0020, BCK | COR), mk(16'h0, NONE)};
        for (int i = 0; i < 4; i++) begin
            cycle(tbl[i]);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL priority_hex step=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL priority_dec step=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
            if (i == 2) begin
                n_cmp++;
                if (bus_h.entry_count !== 3'd0 || bus_h.err_pulse !== 1'b0) begin
                    n_fail++; $display("FAIL priority_clear got=%0d/%b want=0/0",
                                       bus_h.entry_count, bus_h.err_pulse);
                end
            end
        end
    endtask

    task automatic test_random();
        keys_t k;
        int    r;
        for (int i = 0; i < 600; i++) begin
            k = '0;
            if ((i % 70) < 45) begin
                r = $urandom_range(0, 99);
                if (r < 40) k.hex = 16'h0001 << $urandom_range(0, 15);
                else if (r < 46) k.hex = 16'($urandom);
                k.enter   = ($urandom_range(0, 99) < 12);
                k.correct = ($urandom_range(0, 99) < 8);
                k.back    = ($urandom_range(0, 99) < 3);
                k.yes     = ($urandom_range(0, 99) < 7);
                k.no      = ($urandom_range(0, 99) < 5);
            end
            cycle(k);
            n_cmp++;
            if (obs_h !== exp_vec(0)) begin
                n_fail++; $display("FAIL random_hex cyc=%0d got=%h want=%h", i, obs_h, exp_vec(0));
            end
            n_cmp++;
            if (obs_d !== exp_vec(1)) begin
                n_fail++; $display("FAIL random_dec cyc=%0d got=%h want=%h", i, obs_d, exp_vec(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(mk(16'h0, BCK));
        cycle(mk(16'h0008, NONE));
        cycle(mk(16'h0, ENT));
        n_cmp++;
        if (bus_h.confirming !== 1'b1 || bus_d.confirming !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_setup got=%b/%b want=1/1", bus_h.confirming, bus_d.confirming);
        end
        rst = 1'b1;
        #2;
        model_reset();
        n_cmp++;
        if (obs_h !== 38'h0) begin
            n_fail++; $display("FAIL reset_mid_hex got=%h want=%h", obs_h, 38'h0);
        end
        n_cmp++;
        if (obs_d !== exp_vec(1)) begin
            n_fail++; $display("FAIL reset_mid_dec got=%h want=%h", obs_d, exp_vec(1));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(mk(16'h0, YES));
        n_cmp++;
        if (obs_h !== exp_vec(0) || bus_h.commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_release got=%h want=%h", obs_h, exp_vec(0));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_commit();
        test_overflow();
        test_reject();
        test_no();
        test_timeout();
        test_priority();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences the one-cycle key pulses from the PS/2 button controller into a complete multi-digit operand entry. Digits accumulate into a nibble-packed buffer, with backspace and clear available. Enter triggers a yes/no confirmation; a confirmed entry is emitted as a single committed value to the downstream game/calculator datapath. The block sits directly between the keyboard button controller and the application FSM.

Parameters:
MAX_DIGITS, 4, maximum number of digits held; value width is 4*MAX_DIGITS.
HEX_EN, 1, 1 = accept A–F; 0 = decimal only (A–F rejected, buffer is packed BCD).
TIMEOUT_CYCLES, 500_000_000, CONFIRM-state timeout in clk cycles; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
key_hex  input  16  one-hot digit pulses; bit n = hex digit n (bits 0–9 from key_0..key_9, bits 10–15 from key_a..key_f)
key_enter  input  1  enter pulse
key_correct  input  1  backspace pulse
key_back  input  1  clear-all pulse (shift)
key_yes  input  1  confirm pulse (O)
key_no  input  1  reject pulse (X)
entry_value  output  4*MAX_DIGITS  current buffer, right-aligned, newest digit in [3:0]
entry_count  output  $clog2(MAX_DIGITS+1)  number of digits held
confirming  output  1  high while in CONFIRM
commit_valid  output  1  one-cycle pulse; commit_value is valid
commit_value  output  4*MAX_DIGITS  value committed; holds until next commit
err_pulse  output  1  one-cycle pulse on rejected input

Behaviour:
- Reset: state = EDIT; entry_value, entry_count, commit_value = 0; confirming, commit_valid, err_pulse = 0; timeout counter = 0.
- All outputs are registered. Each output reflects a key pulse 1 cycle after it arrives.
- Inputs are single-cycle pulses, sampled only when high. There is no internal edge detection.
- EDIT state: at most one action per cycle, in this priority order:
  1. key_back: buffer = 0, count = 0.
  2. key_correct: if count > 0, value >>= 4 and count -= 1. If count = 0, raise err_pulse with no change.
  3. key_enter: if count > 0, go to CONFIRM and load the timeout counter. If count = 0, raise err_pulse.
  4. Digit:
     - If popcount(key_hex) > 1, raise err_pulse and ignore the digit.
     - If HEX_EN = 0 and any of bits 10–15 are set, raise err_pulse.
     - If count = MAX_DIGITS, raise err_pulse; the buffer is unchanged (no wrap, no shift-out).
     - Otherwise, value = (value << 4) | d and count += 1.
- In EDIT, key_yes and key_no are ignored with no error.
- CONFIRM state (confirming = 1):
  - key_back: clear the buffer and go to EDIT.
  - key_no: go to EDIT with the buffer retained. key_no wins if key_yes and key_no arrive in the same cycle.
  - key_yes: commit_value = entry_value, pulse commit_valid, clear the buffer, go to EDIT.
  - Digits, key_enter and key_correct are ignored silently.
  - Timeout: when TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES-1 with no yes/no/back, go to EDIT with the buffer retained and pulse err_pulse.
  - Any key pulse resets the timeout counter.
- Reset asserted mid-operation (any state) returns to reset values immediately. commit_valid is never emitted on the cycle reset releases.
- Leading zeros count as digits: entering 0,0 gives count = 2, value = 0.

Decomposition:
- Shared package holds:
  - state enum {EDIT, CONFIRM}
  - DIGIT_W = 4
  - the key_hex bit assignment constants, shared with the button controller wrapper
- One sub-module, onehot16_enc: 16-bit one-hot to 4-bit index encoder with a multi_hot flag. It is also reusable by the display scanner.

Test Plan:
- Reset, then key_hex pulses 0x0002, 0x0100, 0x0800 (digits 1,8,B) → entry_value = 0x018B, count = 3; enter → confirming = 1; yes → commit_valid for 1 cycle, commit_value = 0x018B, entry_value = 0, count = 0.
- Enter 5 digits 1,2,3,4,5 with MAX_DIGITS = 4 → value = 0x1234, count = 4, err_pulse on the 5th only; backspace ×2 → 0x0012, count = 2; backspace ×3 → 0, with err_pulse on the 3rd.
- HEX_EN = 0: digit A → err_pulse, count unchanged. Also, key_hex = 0x0006 (two digits) → err_pulse, no change. Also, enter with count = 0 → err_pulse, stays in EDIT.
- Buffer 0x0042 → enter → no → EDIT with 0x0042 retained. Then enter → yes and no in the same cycle → EDIT, buffer retained, no commit_valid.
- TIMEOUT_CYCLES = 16: enter, then idle 16 cycles → confirming falls and err_pulse fires exactly once, buffer retained. Also, a key_a pulse at cycle 10 in CONFIRM restarts the count.
- Priority: key_back, key_correct and a digit pulse in the same cycle → buffer cleared only. Also, assert rst while confirming → all outputs 0 and state = EDIT, asynchronously.
